// File: rtl/reg_unit_pkg.sv
// Shared types and default parameters for the pipelined-core register unit.
package reg_unit_pkg;
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ru_state_t;

    localparam int XLEN_D    = 32;
    localparam int NREGS_D   = 32;
    localparam int SP_IDX_D  = 2;
    localparam int SP_INIT_D = 1023;
endpackage

// File: rtl/reg_unit_scoreboard.sv
// Per-register busy tracking for in-flight producers; flags RAW hazards on the read ports.
module reg_unit_scoreboard
    import reg_unit_pkg::*;
#(
    parameter int NREGS = NREGS_D,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_run,
    input  logic          i_issue_acc,
    input  logic [AW-1:0] i_issue_rd,
    input  logic          i_wr_en,
    input  logic          i_wr_clr,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [AW-1:0] i_rs1_addr,
    input  logic [AW-1:0] i_rs2_addr,
    output logic          o_rs1_busy,
    output logic          o_rs2_busy
);
    logic [NREGS-1:0] r_busy;
    logic             w_fwd1;
    logic             w_fwd2;

    // Set is applied after clear so a same-cycle newer producer keeps the bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (i_wr_clr)
                r_busy[i_wr_addr] <= 1'b0;
            if (i_issue_acc)
                r_busy[i_issue_rd] <= 1'b1;
        end
    end

    assign w_fwd1     = i_wr_en && (i_wr_addr == i_rs1_addr);
    assign w_fwd2     = i_wr_en && (i_wr_addr == i_rs2_addr);
    assign o_rs1_busy = i_run && (i_rs1_addr != '0) && r_busy[i_rs1_addr] && !w_fwd1;
    assign o_rs2_busy = i_run && (i_rs2_addr != '0) && r_busy[i_rs2_addr] && !w_fwd2;
endmodule

// File: rtl/reg_unit_sb.sv
// Parametrised register file with x0 hardwired, write bypass, post-reset init sweep and RAW scoreboard.
module reg_unit_sb
    import reg_unit_pkg::*;
#(
    parameter int XLEN    = XLEN_D,
    parameter int NREGS   = NREGS_D,
    parameter int AW      = $clog2(NREGS),
    parameter int SP_IDX  = SP_IDX_D,
    parameter int SP_INIT = SP_INIT_D
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall,
    output logic            init_busy
);
    ru_state_t       r_state;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_run;
    logic            w_wr;
    logic            w_issue_acc;
    logic [XLEN-1:0] w_init_val;

    // A reset cycle looks like INIT to the outside even if the state is still RUN.
    assign w_run       = rst_n && (r_state == ST_RUN);
    assign init_busy   = !w_run;
    assign w_wr        = w_run && wr_en && (wr_addr != '0);
    assign stall       = init_busy || rs1_busy || rs2_busy;
    assign w_issue_acc = w_run && issue_en && !stall && (issue_rd != '0);
    assign w_init_val  = (r_cnt == AW'(SP_IDX)) ? XLEN'(SP_INIT) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == AW'(NREGS - 1))
                r_state <= ST_RUN;
        end
    end

    // Storage has no reset; the INIT sweep provides the defined contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_INIT)
                r_regs[r_cnt] <= w_init_val;
            else if (w_wr)
                r_regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (w_run && (rs1_addr != '0))
            rs1_data = (wr_en && (wr_addr == rs1_addr)) ? wr_data : r_regs[rs1_addr];
        if (w_run && (rs2_addr != '0))
            rs2_data = (wr_en && (wr_addr == rs2_addr)) ? wr_data : r_regs[rs2_addr];
    end

    reg_unit_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_run       (w_run),
        .i_issue_acc (w_issue_acc),
        .i_issue_rd  (issue_rd),
        .i_wr_en     (wr_en),
        .i_wr_clr    (w_wr),
        .i_wr_addr   (wr_addr),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy)
    );
endmodule

// File: tb/tb_reg_unit_sb.sv
// Directed bench for reg_unit_sb: init sweep, bypass, x0, scoreboard and mid-run resets.
module tb_reg_unit_sb;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        stall;
    logic        init_busy;

    int n_chk;
    int n_fail;
    int n_init;

    reg_unit_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .stall     (stall),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after rst_n rises; counts sampled cycles with init_busy high (bounded).
    task automatic count_init(output int n);
        n = 0;
        @(negedge clk);
        while (init_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0; issue_en = 0; issue_rd = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        idle();
        rst_n = 0;
        step();
        @(negedge clk);
        chk("rst_init_busy", init_busy, 1);
        chk("rst_stall", stall, 1);
        step();
        rst_n = 1;
        count_init(n_init);
        chk("init_len", n_init, 32);
        chk("run_stall", stall, 0);
        rs1_addr = 2; rs2_addr = 7;
        @(negedge clk);
        chk("x2_sp", rs1_data, 32'd1023);
        chk("x7_zero", rs2_data, 0);

        // write with same-cycle bypass
        step();
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5;
        @(negedge clk);
        chk("bypass_x5", rs1_data, 32'hDEADBEEF);
        step();
        wr_en = 0;
        @(negedge clk);
        chk("stored_x5", rs1_data, 32'hDEADBEEF);
        step();
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rs2_addr = 0;
        @(negedge clk);
        chk("x0_bypass", rs2_data, 0);
        step();
        wr_en = 0;
        @(negedge clk);
        chk("x0_stored", rs2_data, 0);

        // RAW hazard on x9
        step();
        idle();
        issue_en = 1; issue_rd = 9;
        step();
        issue_en = 0; rs1_addr = 9;
        @(negedge clk);
        chk("raw_busy", rs1_busy, 1);
        chk("raw_stall", stall, 1);
        step();
        wr_en = 1; wr_addr = 9; wr_data = 32'h55;
        @(negedge clk);
        chk("wb_fwd_busy", rs1_busy, 0);
        chk("wb_fwd_stall", stall, 0);
        chk("wb_fwd_data", rs1_data, 32'h55);
        step();
        wr_en = 0;
        @(negedge clk);
        chk("wb_cleared", rs1_busy, 0);

        // set wins over same-cycle clear
        step();
        idle();
        issue_en = 1; issue_rd = 9;
        step();
        wr_en = 1; wr_addr = 9; wr_data = 32'h66;
        @(negedge clk);
        chk("setwin_nostall", stall, 0);
        step();
        idle();
        rs1_addr = 9;
        @(negedge clk);
        chk("setwin_busy", rs1_busy, 1);
        step();
        wr_en = 1; wr_addr = 9; wr_data = 32'h77;
        step();
        wr_en = 0;
        @(negedge clk);
        chk("setwin_cleared", rs1_busy, 0);
        chk("setwin_data", rs1_data, 32'h77);

        // issue ignored while stalled; x0 never busy
        step();
        idle();
        issue_en = 1; issue_rd = 4;
        step();
        issue_en = 1; issue_rd = 3; rs2_addr = 4;
        @(negedge clk);
        chk("gate_stall", rs2_busy, 1);
        step();
        idle();
        rs1_addr = 3;
        @(negedge clk);
        chk("gate_x3_idle", rs1_busy, 0);
        step();
        wr_en = 1; wr_addr = 4; wr_data = 1;
        step();
        idle();
        issue_en = 1; issue_rd = 0;
        step();
        issue_en = 0;
        @(negedge clk);
        chk("x0_notbusy", rs1_busy, 0);
        chk("x0_nostall", stall, 0);

        // reset in RUN with x6 busy
        step();
        issue_en = 1; issue_rd = 6;
        step();
        issue_en = 0; rs1_addr = 6;
        @(negedge clk);
        chk("pre_rst_busy", rs1_busy, 1);
        step();
        rst_n = 0;
        @(negedge clk);
        chk("rst_run_busy", rs1_busy, 0);
        chk("rst_run_stall", stall, 1);
        chk("rst_run_data", rs1_data, 0);
        step();
        rst_n = 1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 0;
        step();
        rst_n = 1;
        count_init(n_init);
        chk("reinit_len", n_init, 32);
        chk("reinit_x6_busy", rs1_busy, 0);
        rs2_addr = 5;
        @(negedge clk);
        chk("reinit_x5", rs2_data, 0);
        rs1_addr = 2;
        @(negedge clk);
        chk("reinit_x2", rs1_data, 32'd1023);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
